// File: rtl/csr_cnt_pkg.sv
// csr_cnt_pkg: CSR addresses, op codes, FSM states and inhibit bit positions for the counter controller
package csr_cnt_pkg;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [1:0] CSR_NOP = 2'b00;
  localparam logic [1:0] CSR_RW  = 2'b01;
  localparam logic [1:0] CSR_RS  = 2'b10;
  localparam logic [1:0] CSR_RC  = 2'b11;
  localparam int INH_CY = 0;
  localparam int INH_IR = 2;
  localparam logic [2:0] INH_MASK = 3'b101;
  typedef enum logic {IDLE, EXEC} state_t;
  function automatic logic is_cnt_addr(input logic [11:0] a);
    return a inside {CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
                     CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH};
  endfunction
endpackage

// File: rtl/csr_counter_ctrl_cnt64.sv
// cnt64: wrapping counter split into two halves; a written half overrides that cycle's increment
module cnt64 #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           inc,
  input  logic           wr_lo,
  input  logic           wr_hi,
  input  logic [W/2-1:0] wdata,
  output logic [W-1:0]   value
);
  localparam int H = W / 2;
  logic [W-1:0] value_q, value_d, sum;
  always_comb begin
    sum = value_q + {{(W-1){1'b0}}, inc};
    value_d = {wr_hi ? wdata : sum[W-1:H], wr_lo ? wdata : sum[H-1:0]};
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) value_q <= '0;
    else         value_q <= value_d;
  end
  assign value = value_q;
endmodule

// File: rtl/csr_counter_ctrl.sv
// csr_counter_ctrl: two-cycle read-modify-write access to cycle/instret counters and mcountinhibit
module csr_counter_ctrl
  import csr_cnt_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_wdata,
  input  logic        retire,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal
);
  localparam int H = CNT_W / 2;
  state_t state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [H-1:0] new_q, new_d, rdata_q, rdata_d, cnt_word, old_word;
  logic wr_q, wr_d, ill_q, ill_d, accept, is_inh, writes, illegal;
  logic [2:0] inh_q, inh_d;
  logic [CNT_W-1:0] cy_cnt, ir_cnt;
  always_comb begin
    is_inh = req_addr == CSR_MCOUNTINHIBIT;
    writes = req_op == CSR_RW || req_wdata != '0;
    illegal = !(is_cnt_addr(req_addr) || is_inh) || (req_addr[11:8] == 4'hC && writes);
    cnt_word = req_addr[1] ? (req_addr[7] ? ir_cnt[CNT_W-1:H] : ir_cnt[H-1:0])
                           : (req_addr[7] ? cy_cnt[CNT_W-1:H] : cy_cnt[H-1:0]);
    old_word = is_inh ? {{(H-3){1'b0}}, inh_q} : cnt_word;
    accept = req_valid && state_q == IDLE && req_op != CSR_NOP;
    state_d = accept ? EXEC : IDLE;
    addr_d = accept ? req_addr : addr_q;
    new_d = !accept ? new_q :
            req_op == CSR_RW ? req_wdata :
            req_op == CSR_RS ? (old_word | req_wdata) : (old_word & ~req_wdata);
    wr_d = accept && !illegal && writes;
    ill_d = accept && illegal;
    rdata_d = (accept && !illegal) ? old_word : '0;
    // the new inhibit value gates increments only from the edge after the commit
    inh_d = (wr_q && addr_q == CSR_MCOUNTINHIBIT) ? (new_q[2:0] & INH_MASK) : inh_q;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      new_q   <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      rdata_q <= '0;
      inh_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      new_q   <= new_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
      rdata_q <= rdata_d;
      inh_q   <= inh_d;
    end
  end
  cnt64 #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .nreset(nreset),
    .inc   (!inh_q[INH_CY]),
    .wr_lo (wr_q && addr_q == CSR_MCYCLE),
    .wr_hi (wr_q && addr_q == CSR_MCYCLEH),
    .wdata (new_q),
    .value (cy_cnt)
  );
  cnt64 #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .nreset(nreset),
    .inc   (retire && !inh_q[INH_IR]),
    .wr_lo (wr_q && addr_q == CSR_MINSTRET),
    .wr_hi (wr_q && addr_q == CSR_MINSTRETH),
    .wdata (new_q),
    .value (ir_cnt)
  );
  assign req_ready   = state_q == IDLE;
  assign rsp_valid   = state_q == EXEC;
  assign rsp_rdata   = rdata_q;
  assign rsp_illegal = ill_q;
endmodule

// File: tb/tb_csr_counter_ctrl.sv
// tb_csr_counter_ctrl: randomized + directed scoreboard bench against a 64-bit arithmetic counter model
module tb_csr_counter_ctrl;
  logic clk, nreset, req_valid, req_ready, retire, rsp_valid, rsp_illegal;
  logic [11:0] req_addr;
  logic [1:0] req_op;
  logic [31:0] req_wdata, rsp_rdata;
  csr_counter_ctrl #(.CNT_W(64)) dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata), .retire(retire),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {logic [31:0] d; logic il;} exp_t;
  exp_t q[$];
  exp_t me, xe;
  int checks = 0, fails = 0;
  logic [63:0] m_cyc, m_ins, nc, ni, base;
  logic [2:0] m_inh, ninh;
  logic m_busy = 0, m_pend, wr, ill;
  logic [11:0] p_addr;
  logic [31:0] p_new, old, last_rdata;
  logic last_ill;
  time last_t, prev_t;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // reference model: full 64-bit counters, commit replaces one 32-bit half of the incremented value
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_cyc = '0; m_ins = '0; m_inh = '0; m_busy = 0; m_pend = 0;
      q.delete();
    end else begin
      nc = m_cyc + (m_inh[0] ? 64'd0 : 64'd1);
      ni = m_ins + ((retire && !m_inh[2]) ? 64'd1 : 64'd0);
      ninh = m_inh;
      if (m_pend) begin
        if (p_addr == 12'hB00) nc = (nc & 64'hFFFF_FFFF_0000_0000) | 64'(p_new);
        if (p_addr == 12'hB80) nc = (nc & 64'h0000_0000_FFFF_FFFF) | (64'(p_new) << 32);
        if (p_addr == 12'hB02) ni = (ni & 64'hFFFF_FFFF_0000_0000) | 64'(p_new);
        if (p_addr == 12'hB82) ni = (ni & 64'h0000_0000_FFFF_FFFF) | (64'(p_new) << 32);
        if (p_addr == 12'h320) ninh = p_new[2:0] & 3'b101;
      end
      m_pend = 0;
      if (req_valid && !m_busy && req_op != 2'b00) begin
        base = req_addr[1] ? m_ins : m_cyc;
        old = (req_addr == 12'h320) ? {29'b0, m_inh} : (req_addr[7] ? base[63:32] : base[31:0]);
        wr = req_op == 2'b01 || req_wdata != 0;
        ill = !(req_addr inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                 12'hC02, 12'hC82, 12'h320}) || (req_addr[11:8] == 4'hC && wr);
        me.d = ill ? 32'd0 : old;
        me.il = ill;
        q.push_back(me);
        m_pend = !ill && wr;
        p_addr = req_addr;
        p_new = req_op == 2'b01 ? req_wdata : req_op == 2'b10 ? (old | req_wdata) : (old & ~req_wdata);
        m_busy = 1;
        prev_t = last_t;
        last_t = $time;
      end else m_busy = 0;
      m_cyc = nc; m_ins = ni; m_inh = ninh;
    end
  end
  always @(negedge clk) begin
    chk("req_ready", {63'b0, req_ready}, {63'b0, !m_busy});
    if (q.size() > 0) begin
      xe = q.pop_front();
      chk("rsp_valid", {63'b0, rsp_valid}, 64'd1);
      chk("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, xe.d});
      chk("rsp_illegal", {63'b0, rsp_illegal}, {63'b0, xe.il});
      last_rdata = rsp_rdata;
      last_ill = rsp_illegal;
    end else chk("spurious_rsp", {63'b0, rsp_valid}, 64'd0);
  end
  task automatic issue(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w);
    bit done = 0;
    req_valid = 1; req_addr = a; req_op = o; req_wdata = w;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL issue_timeout: addr %0h never accepted", a);
    end
    req_valid = 0;
  endtask
  task automatic read_back();
    @(posedge clk);
    #1;
  endtask
  logic [11:0] addrs [12];
  initial begin
    addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
              12'hC02, 12'hC82, 12'h320, 12'h320, 12'h7FF, 12'hB01};
    nreset = 0; req_valid = 0; req_addr = 0; req_op = 0; req_wdata = 0; retire = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'b0, req_ready}, 64'd1);
    chk("reset_valid", {63'b0, rsp_valid}, 64'd0);
    chk("reset_rdata", {32'b0, rsp_rdata}, 64'd0);
    chk("reset_illegal", {63'b0, rsp_illegal}, 64'd0);
    nreset = 1;
    repeat (10) @(posedge clk);
    #1;
    issue(12'hB00, 2'b10, 0); read_back();
    chk("cycle_at_10", {32'b0, last_rdata}, 64'd10);
    chk("cycle_at_10_legal", {63'b0, last_ill}, 64'd0);
    issue(12'hB00, 2'b01, 32'hFFFF_FFFF);
    issue(12'hB80, 2'b10, 0); read_back();
    chk("hi_before_wrap", {32'b0, last_rdata}, 64'd0);
    issue(12'hB80, 2'b10, 0); read_back();
    chk("hi_after_wrap", {32'b0, last_rdata}, 64'd1);
    issue(12'h320, 2'b01, 32'h5);
    issue(12'hB00, 2'b10, 0);
    issue(12'hB02, 2'b11, 0);
    for (int i = 0; i < 20; i++) begin
      retire = i[0];
      @(posedge clk);
      #1;
    end
    retire = 0;
    issue(12'hB00, 2'b10, 0);
    issue(12'hB02, 2'b10, 0);
    issue(12'h320, 2'b11, 32'hFFFF_FFFF);
    retire = 1;
    repeat (5) @(posedge clk);
    #1;
    issue(12'hB00, 2'b10, 0);
    issue(12'hB02, 2'b10, 0);
    retire = 0;
    issue(12'hC00, 2'b10, 1); read_back();
    chk("ro_write_ill", {63'b0, last_ill}, 64'd1);
    chk("ro_write_rdata", {32'b0, last_rdata}, 64'd0);
    issue(12'hC00, 2'b10, 0); read_back();
    chk("ro_read_legal", {63'b0, last_ill}, 64'd0);
    issue(12'h7FF, 2'b10, 0); read_back();
    chk("undecoded_ill", {63'b0, last_ill}, 64'd1);
    issue(12'hC82, 2'b01, 0); read_back();
    chk("ro_rw_ill", {63'b0, last_ill}, 64'd1);
    retire = 1;
    issue(12'hB00, 2'b10, 0);
    issue(12'hB02, 2'b11, 32'h0000_000F);
    chk("b2b_gap", 64'(last_t - prev_t), 64'd20);
    retire = 0;
    issue(12'hB02, 2'b10, 0);
    req_valid = 1; req_op = 2'b00; req_addr = 12'hB00;
    repeat (4) @(posedge clk);
    #1;
    req_valid = 0;
    issue(12'hB02, 2'b10, 0);
    nreset = 0;
    #1;
    chk("midop_valid", {63'b0, rsp_valid}, 64'd0);
    chk("midop_ready", {63'b0, req_ready}, 64'd1);
    chk("midop_rdata", {32'b0, rsp_rdata}, 64'd0);
    chk("midop_illegal", {63'b0, rsp_illegal}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1;
    repeat (5) @(posedge clk);
    #1;
    issue(12'hB00, 2'b10, 0); read_back();
    chk("cycle_after_reset", {32'b0, last_rdata}, 64'd5);
    issue(12'hB02, 2'b10, 0); read_back();
    chk("instret_after_reset", {32'b0, last_rdata}, 64'd0);
    for (int i = 0; i < 1500; i++) begin
      req_valid = $urandom_range(0, 1) == 1;
      req_op = 2'($urandom);
      req_addr = addrs[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0: req_wdata = 0;
        1: req_wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: req_wdata = $urandom;
      endcase
      retire = $urandom_range(0, 1) == 1;
      nreset = (i != 700);
      @(posedge clk);
      #1;
    end
    req_valid = 0; retire = 0; nreset = 1;
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/csr_counter_ctrl.md
# csr_counter_ctrl

Controller for the hardware performance counters (cycle, instret) of the CSR unit. Accepts CSR access requests from the execute stage and sequences each one as a two-cycle read-modify-write:
- cycle 1 captures the old counter value;
- cycle 2 returns it and commits the new value.

Also owns the 64-bit counter state, per-cycle/per-retire increment, `mcountinhibit` gating and access legality checks.

## Interface
Parameters:
- `CNT_W`, 64, counter width (fixed split into two 32-bit halves)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `nreset`  in  1  reset; **asynchronous, active-low**
- `req_valid`  in  1  CSR access request
- `req_ready`  out  1  high when a request can be accepted
- `req_addr`  in  12  CSR address
- `req_op`  in  2  01 CSRRW, 10 CSRRS, 11 CSRRC, 00 no-op (ignored, never accepted)
- `req_wdata`  in  32  source operand
- `retire`  in  1  one-cycle pulse per retired instruction
- `rsp_valid`  out  1  response strobe, one cycle
- `rsp_rdata`  out  32  old CSR value
- `rsp_illegal`  out  1  access illegal; qualifies `rsp_valid`

## Operation
- Decoded addresses:
  - 0xB00/0xB80 `mcycle`/`mcycleh`
  - 0xB02/0xB82 `minstret`/`minstreth`
  - 0xC00/0xC80 `cycle`/`cycleh`, read-only shadows
  - 0xC02/0xC82 `instret`/`instreth`, read-only shadows
  - 0x320 `mcountinhibit`: bit0 CY, bit2 IR; other bits read 0 and are not writable
- Counting: `cycle` += 1 every clock unless CY=1. `instret` += 1 on each clock with `retire`=1 unless IR=1. Both wrap 2^64−1 → 0 silently.
- Request accept: `req_valid` & `req_ready` & `req_op`≠00.
- FSM states:
  - IDLE: `req_ready`=1. On accept → EXEC; latch address, op, wdata and the selected 32-bit word as `old`. The latched value is the pre-edge value in the accept cycle.
  - EXEC: `req_ready`=0; `rsp_valid`=1, `rsp_rdata`=`old`. Commit `new` at the end of the cycle, then → IDLE.
- `new` per op:
  - RW: `wdata`
  - RS: `old | wdata`
  - RC: `old & ~wdata`
- Pure read: RS/RC with `wdata`=0. No write, never illegal on a decoded address.
- Illegal (`rsp_illegal`=1, `rsp_rdata`=0, no state change):
  - undecoded address, or
  - a write (RW, or RS/RC with `wdata`≠0) to a 0xCxx address.
- Commit collision: a committed half overrides that cycle's increment of that half. The other half takes its normal incremented value, including any carry from the old low half. Increments during EXEC before the commit are discarded for the written half.
- Writing `mcountinhibit` takes effect from the clock after commit.
- Reset mid-operation: FSM → IDLE, pending response dropped.

## Timing
- Reset values:
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_illegal`=0
  - counters 0, `mcountinhibit` 0
- First `cycle` increment on the first rising edge after `nreset` deasserts.
- Latency: response exactly 1 cycle after accept. Throughput: 1 request per 2 cycles.
- `rsp_*` registered; valid for exactly one cycle; no backpressure on the response.
- `retire` during EXEC counts normally.

## Structure
- Package `csr_cnt_pkg`:
  - CSR address localparams
  - op encoding (`CSR_RW`/`CSR_RS`/`CSR_RC`)
  - FSM enum {IDLE, EXEC}
  - inhibit bit indices
- Sub-module `cnt64`, instantiated twice (cycle, instret). Inputs: `inc`, `wr_lo`, `wr_hi`, `wdata`. Output: 64-bit value. Write priority and carry rules as above.
- Top level holds: decoder, legality check, FSM, latches, `mcountinhibit` register.

## Test plan
- Reset, release, issue RS 0xB00 wdata=0 at cycle 10 after release → `rsp_rdata`=10 next cycle, `rsp_illegal`=0.
- RW 0xB00 wdata=0xFFFFFFFF, then pure-read 0xB80 → high half incremented by 1 in the cycle after the low half wraps.
- RW 0x320 wdata=0x5. Two reads of 0xB00 and two of 0xB02, 20 cycles apart with `retire` pulses → values unchanged. Re-enable → counting resumes.
- RS 0xC00 wdata=1 → `rsp_illegal`=1, `rsp_rdata`=0, counter unaffected. RS 0xC00 wdata=0 → legal read. Address 0x7FF → illegal.
- Back-to-back `req_valid` → `req_ready`=0 in EXEC, second request accepted 2 cycles after the first. RC 0xB02 with `retire` in the commit cycle → written value wins for `minstret`.
- Assert `nreset` during EXEC → no `rsp_valid`, all outputs and counters at reset values.
